// File: rtl/etc_rgb_block_sequencer.sv
// etc_rgb_block_sequencer
//   Accepts one 64-bit ETC1/ETC2 colour block, decodes its two base colours
//   (individual or differential mode) to 8-bit RGB, then walks the block's
//   16 pixel indices towards the pixel-colour stage.
//
// Ports
//   sclk               clock, rising edge
//   rsrt               asynchronous active-low reset
//   blk_valid/ready    block handshake; blk_data bits 31:0 are pixel indices
//   blk_punch          block belongs to a punch-through texture
//   blk_alpha          texture carries alpha, presented as aplha
//   dn_hold            downstream stall, freezes pixel sequencing
//   rtr, pixIdx        pixel request valid and current pixel index 0..15
//   block, flipped     registered block and its flip bit
//   flag_punchThrough  punch-through block with the opaque bit clear
//   baseColor_0/1      {b,g,r} base colours of sub-blocks 0 and 1
//   blk_done           pulse on the pixIdx==15 beat
//   unsup              pulse while a T/H/planar block is in decode
//   err_cnt            saturating count of unsupported blocks
module etc_rgb_block_sequencer #(
    parameter bit          SKIP_INVALID = 1'b1,
    parameter int unsigned ERR_CNT_W    = 16
) (
    input  logic                 sclk,
    input  logic                 rsrt,
    input  logic                 blk_valid,
    output logic                 blk_ready,
    input  logic [63:0]          blk_data,
    input  logic                 blk_punch,
    input  logic                 blk_alpha,
    input  logic                 dn_hold,
    output logic                 rtr,
    output logic [3:0]           pixIdx,
    output logic [63:0]          block,
    output logic                 flipped,
    output logic                 flag_punchThrough,
    output logic                 aplha,
    output logic [23:0]          baseColor_0,
    output logic [23:0]          baseColor_1,
    output logic                 blk_done,
    output logic                 unsup,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, DECODE, EMIT} state_t;

    state_t               state;
    logic                 ready_q;
    logic [3:0]           pix_q;
    logic [63:0]          blk_q;
    logic                 punch_q;
    logic                 alpha_q;
    logic [23:0]          c0_q;
    logic [23:0]          c1_q;
    logic                 inv_q;
    logic [ERR_CNT_W-1:0] err_q;

    logic                 hs;
    logic                 diff_in;
    logic [5:0]           sum_r;
    logic [5:0]           sum_g;
    logic [5:0]           sum_b;
    logic [23:0]          dec_c0;
    logic [23:0]          dec_c1;
    logic                 dec_inv;

    function automatic logic [7:0] exp5(input logic [4:0] x);
        return {x, x[4:2]};
    endfunction

    // Base colours are decoded straight from the incoming block so they are
    // registered together with it and are already valid during DECODE.
    always_comb begin
        diff_in = blk_data[33] | blk_punch;
        sum_r   = {1'b0, blk_data[63:59]} + {{3{blk_data[58]}}, blk_data[58:56]};
        sum_g   = {1'b0, blk_data[55:51]} + {{3{blk_data[50]}}, blk_data[50:48]};
        sum_b   = {1'b0, blk_data[47:43]} + {{3{blk_data[42]}}, blk_data[42:40]};
        if (diff_in) begin
            dec_c0  = {exp5(blk_data[47:43]), exp5(blk_data[55:51]), exp5(blk_data[63:59])};
            dec_c1  = {exp5(sum_b[4:0]), exp5(sum_g[4:0]), exp5(sum_r[4:0])};
            // Sums span -4..34, so bit 5 is set exactly when outside 0..31.
            dec_inv = sum_r[5] | sum_g[5] | sum_b[5];
        end else begin
            dec_c0  = {blk_data[47:44], blk_data[47:44], blk_data[55:52], blk_data[55:52],
                       blk_data[63:60], blk_data[63:60]};
            dec_c1  = {blk_data[43:40], blk_data[43:40], blk_data[51:48], blk_data[51:48],
                       blk_data[59:56], blk_data[59:56]};
            dec_inv = 1'b0;
        end
    end

    assign rtr               = (state == EMIT) && !dn_hold;
    assign blk_done          = rtr && (pix_q == 4'd15);
    assign blk_ready         = ready_q | blk_done;
    assign hs                = blk_valid && blk_ready;
    assign pixIdx            = pix_q;
    assign block             = blk_q;
    assign flipped           = blk_q[32];
    assign flag_punchThrough = punch_q && !blk_q[33];
    assign aplha             = alpha_q;
    assign baseColor_0       = c0_q;
    assign baseColor_1       = c1_q;
    assign unsup             = (state == DECODE) && inv_q;
    assign err_cnt           = err_q;

    // Every handshake (IDLE or the last EMIT beat) captures a new block.
    always_ff @(posedge sclk or negedge rsrt) begin
        if (!rsrt) begin
            blk_q   <= '0;
            punch_q <= 1'b0;
            alpha_q <= 1'b0;
            c0_q    <= '0;
            c1_q    <= '0;
            inv_q   <= 1'b0;
        end else if (hs) begin
            blk_q   <= blk_data;
            punch_q <= blk_punch;
            alpha_q <= blk_alpha;
            c0_q    <= dec_c0;
            c1_q    <= dec_c1;
            inv_q   <= dec_inv;
        end
    end

    always_ff @(posedge sclk or negedge rsrt) begin
        if (!rsrt) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            pix_q   <= '0;
            err_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        ready_q <= 1'b0;
                        state   <= DECODE;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                DECODE: begin
                    if (inv_q && (err_q != '1)) begin
                        err_q <= err_q + ERR_CNT_W'(1);
                    end
                    if (inv_q && SKIP_INVALID) begin
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        pix_q <= '0;
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (rtr) begin
                        if (pix_q == 4'd15) begin
                            pix_q <= '0;
                            if (hs) begin
                                state <= DECODE;
                            end else begin
                                ready_q <= 1'b1;
                                state   <= IDLE;
                            end
                        end else begin
                            pix_q <= pix_q + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/etc_rgb_block_sequencer.md
Name: etc_rgb_block_sequencer

Overview:
- Upstream stage of the ETC RGB pixel-colour stage.
- Accepts one 64-bit ETC1/ETC2 colour block over a valid/ready handshake and decodes the individual or differential base colours into 8-bit RGB.
- Then sequences the block's 16 pixels by driving rtr/pixIdx for 16 cycles, together with block, flipped, baseColor_0/1, flag_punchThrough and aplha.
- ETC2 T/H/planar blocks are detected and handled per SKIP_INVALID.

Parameters:
- SKIP_INVALID, 1: 1 = consume T/H/planar blocks and emit no pixels; 0 = emit them with the base colours computed from the truncated 5-bit sums.
- ERR_CNT_W, 16: width of the unsupported-block counter.

Ports:
- sclk  in  1  clock, all logic on its rising edge
- rsrt  in  1  reset; asynchronous, active-low
- blk_valid  in  1  upstream block valid
- blk_ready  out  1  block accepted when blk_valid&&blk_ready
- blk_data  in  64  ETC colour block; bits 31:0 are the pixel index bits
- blk_punch  in  1  block belongs to a punch-through texture
- blk_alpha  in  1  texture carries alpha; passed through as aplha
- dn_hold  in  1  downstream stall; freezes pixel sequencing
- rtr  out  1  pixel request valid to the colour stage
- pixIdx  out  4  current pixel index, 0..15
- block  out  64  registered accepted block
- flipped  out  1  block[32]
- flag_punchThrough  out  1  blk_punch && !block[33]
- aplha  out  1  registered blk_alpha
- baseColor_0  out  24  {b,g,r} 8-bit each, sub-block 0
- baseColor_1  out  24  {b,g,r} 8-bit each, sub-block 1
- blk_done  out  1  one-cycle pulse with the pixIdx==15 beat
- unsup  out  1  one-cycle pulse when a T/H/planar block is decoded
- err_cnt  out  ERR_CNT_W  saturating count of unsup pulses

Behaviour:
- Reset (rsrt low, asynchronous) forces IDLE. All outputs are 0, except blk_ready, which is 0 during reset and 1 in the first IDLE cycle after rsrt rises.
- Reset mid-block abandons the block immediately; no partial blk_done is produced.
- States:
  - IDLE: blk_ready=1. On handshake, capture blk_data, blk_punch and blk_alpha, then go to DECODE.
  - DECODE, exactly 1 cycle: blk_ready=0, rtr=0. Register base colours and flags. If the block is invalid and SKIP_INVALID=1, pulse unsup and return to IDLE. Otherwise pulse unsup if invalid and go to EMIT with pixIdx=0.
  - EMIT: rtr = !dn_hold. pixIdx increments only on cycles with rtr=1. While dn_hold=1, every output holds its value.
  - EMIT, last beat (pixIdx==15 and rtr=1): blk_done=1 and blk_ready=1.
    - If a handshake occurs on that beat: capture the new block and go to DECODE, giving 17 cycles per block back-to-back.
    - Otherwise go to IDLE.
  - blk_ready is 0 on every other EMIT cycle.
- Mode selection: diff = block[33], or 1 whenever blk_punch=1 (in punch-through, bit 33 is the opaque bit).
- Individual mode (diff=0):
  - R1=[63:60], R2=[59:56], G1=[55:52], G2=[51:48], B1=[47:44], B2=[43:40].
  - 4-bit to 8-bit expansion: {x,x}.
- Differential mode (diff=1):
  - R=[63:59] with dR=[58:56] signed 3-bit; G=[55:51] with dG=[50:48]; B=[47:43] with dB=[42:40].
  - Channel 2 = channel + d, computed in 6-bit signed.
  - A result outside 0..31 marks the block invalid: R overflow = T mode, G = H mode, B = planar.
  - 5-bit to 8-bit expansion: {x, x[4:2]}. For invalid blocks with SKIP_INVALID=0, use the low 5 bits of the sum.
- Packing: baseColor_n = {B,G,R}; r occupies [7:0].
- block, flipped, flag_punchThrough, aplha and baseColor_* stay stable from DECODE through the last EMIT beat.
- err_cnt saturates at all-ones. It is cleared only by reset.

Test Plan:
- Individual mode: blk_data=64'hA53CF024_0000FFFF, blk_punch=0, dn_hold=0.
  - Expect baseColor_0=24'hFF33AA, baseColor_1=24'h00CC55, flipped=0.
  - Expect 16 consecutive rtr beats with pixIdx 0..15, then blk_done on beat 15.
- Differential mode: blk_data[63:32]=32'h8347F803.
  - Expect baseColor_0=24'hFF4284, baseColor_1=24'hFF399C, flipped=1.
- Punch-through: the differential block above with [33]=0 and blk_punch=1.
  - Expect differential decode anyway and flag_punchThrough=1.
  - Repeat with [33]=1: expect flag_punchThrough=0.
- Invalid block: blk_data[63:56]=8'hF9 with diff=1 and SKIP_INVALID=1.
  - Expect unsup pulse, err_cnt=1, no rtr beats, blk_ready=1 two cycles after acceptance.
- Stall and back-to-back: hold dn_hold=1 for 3 cycles at pixIdx=7, with a second block pending.
  - Expect rtr=0 and pixIdx frozen at 7 during the stall.
  - Expect the second block accepted on the beat-15 cycle and the first rtr of block 2 exactly 2 cycles later.
- Async reset: assert rsrt=0 at pixIdx=9.
  - Expect rtr=0, pixIdx=0 and blk_ready=0 immediately, with no blk_done.
  - After release, expect blk_ready=1 and normal operation.
